// File: rtl/px_stream_hub.sv
// px_stream_hub: mode-selectable pixel crossbar with credit flow control, output FIFO and per-frame pixel counting
module px_stream_hub #(
  parameter int PX_W = 24,
  parameter int FIFO_DEPTH = 4,
  parameter int FRAME_PX = 16
) (
  input  logic                        clk_i,
  input  logic                        nreset_i,
  input  logic [1:0]                  mode_i,
  input  logic [PX_W-1:0]             host_px_i,
  input  logic                        host_rdy_i,
  output logic [PX_W-1:0]             host_px_o,
  output logic                        host_valid_o,
  input  logic                        host_pop_i,
  output logic [PX_W-1:0]             proc_px_o,
  output logic                        proc_rdy_o,
  input  logic [PX_W-1:0]             proc_px_i,
  input  logic                        proc_rdy_i,
  input  logic [PX_W-1:0]             lfsr_px_i,
  input  logic                        lfsr_rdy_i,
  output logic [PX_W-1:0]             cfg_px_o,
  output logic                        cfg_rdy_o,
  input  logic [PX_W-1:0]             cfg_px_i,
  input  logic                        cfg_rdy_i,
  output logic                        busy_o,
  output logic                        drop_o,
  output logic                        frame_done_o,
  output logic [$clog2(FRAME_PX)-1:0] px_count_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PCW = $clog2(FRAME_PX);
  localparam logic [PCW-1:0] LAST_PX = PCW'(FRAME_PX - 1);
  logic [1:0]      mode_q;
  logic [PX_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count, inflight;
  logic [CW:0]     used;
  logic            pending, src_stb, accept, ret, push, pop, to_proc, to_cfg;
  logic [PX_W-1:0] src_px, push_px;
  always_comb begin
    pending = mode_i != mode_q;
    src_stb = mode_q == 2'd1 ? lfsr_rdy_i : host_rdy_i;
    src_px  = mode_q == 2'd1 ? lfsr_px_i : host_px_i;
    used    = {1'b0, count} + {1'b0, inflight};
    // credits cover both queued words and words still inside the pipeline
    accept  = src_stb && !pending && used < (CW+1)'(FIFO_DEPTH);
    to_proc = accept && !mode_q[1];
    to_cfg  = accept && mode_q == 2'd2;
    ret     = inflight != '0 && (mode_q == 2'd2 ? cfg_rdy_i : (mode_q != 2'd3 && proc_rdy_i));
    push    = ret || (accept && mode_q == 2'd3);
    push_px = mode_q == 2'd3 ? src_px : (mode_q == 2'd2 ? cfg_px_i : proc_px_i);
    pop     = host_pop_i && count != '0;
  end
  assign host_valid_o = count != '0;
  assign host_px_o    = host_valid_o ? mem[rd_ptr] : '0;
  assign busy_o       = host_valid_o || inflight != '0 || pending;
  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      mode_q       <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      inflight     <= '0;
      proc_px_o    <= '0;
      proc_rdy_o   <= 1'b0;
      cfg_px_o     <= '0;
      cfg_rdy_o    <= 1'b0;
      drop_o       <= 1'b0;
      frame_done_o <= 1'b0;
      px_count_o   <= '0;
    end else begin
      proc_rdy_o   <= to_proc;
      cfg_rdy_o    <= to_cfg;
      if (to_proc) proc_px_o <= src_px;
      if (to_cfg) cfg_px_o <= src_px;
      if (src_stb && !accept) drop_o <= 1'b1;
      if (push) begin
        mem[wr_ptr] <= push_px;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count        <= count + CW'(push) - CW'(pop);
      inflight     <= inflight + CW'(accept && mode_q != 2'd3) - CW'(ret);
      frame_done_o <= push && px_count_o == LAST_PX;
      if (push) px_count_o <= px_count_o == LAST_PX ? '0 : px_count_o + PCW'(1);
      if (pending && count == '0 && inflight == '0) mode_q <= mode_i;
    end
  end
endmodule
